// File: rtl/seq_detect_n.sv
// rtl/seq_detect_n.sv - runtime-loadable serial pattern detector with overlap select; optional match counter under SEQDET_CNT_EN
module seq_detect_n #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(4'b1010)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] hist;
  // fill is the detector state: 0..PAT_W-1 collecting, PAT_W primed
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] h_next;
  logic [FW-1:0]    f_next;
  logic             hit;

  // next history/fill and match decode; a load edge never produces a match
  always_comb begin
    h_next = {hist[PAT_W-2:0], in};
    f_next = (fill == FULL) ? FULL : fill + 1'b1;
    hit    = in_valid && !pat_load && (f_next == FULL) && (h_next == pat_q);
  end

  // pattern register, history, fill level and registered match pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q <= RESET_PAT;
      hist  <= '0;
      fill  <= '0;
      z     <= 1'b0;
    end else if (pat_load) begin
      pat_q <= pattern;
      hist  <= '0;
      fill  <= '0;
      z     <= 1'b0;
    end else if (in_valid) begin
      hist <= h_next;
      // non-overlap restarts collection so the next match needs fresh bits
      fill <= (hit && !overlap) ? '0 : f_next;
      z    <= hit;
    end else begin
      z <= 1'b0;
    end
  end

`ifdef SEQDET_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt;

  // saturating match counter; a clear on a match edge counts that match
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign match_cnt = cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt = '0;
`endif

endmodule

// File: doc/seq_detect_n.md
# seq_detect_n

Parametrised serial sequence detector. It matches a runtime-loadable PAT_W-bit pattern against a one-bit-per-cycle input stream, with overlapping or non-overlapping detection selectable at runtime. It generalises the team's fixed "1 then 0" detector: configured with PAT_W=2 and pattern 2'b10 with overlap on, it gives the same detection. It sits at the front end of the bit-stream control path and feeds a registered match pulse and an optional match counter downstream.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- CNT_W, 8, match counter width.
- RESET_PAT, 4'b1010 (PAT_W bits), pattern register value after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-low. Sampled only on the rising clk edge.
- in  input  1  serial data bit.
- in_valid  input  1  in is consumed on this edge when high.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- pat_load  input  1  load pattern into the pattern register and flush history.
- pattern  input  PAT_W  new pattern; MSB is the first bit of the sequence.
- cnt_clr  input  1  zero match_cnt.
- z  output  1  registered match pulse.
- match_cnt  output  CNT_W  saturating count of matches.

## Operation
- State held:
  - pat_q[PAT_W-1:0], the pattern register.
  - hist[PAT_W-1:0], the bit history; newest bit in the LSB.
  - fill, counting 0..PAT_W and saturating at PAT_W.
  - z.
  - cnt.
- Reset (rst=0 at an edge):
  - pat_q=RESET_PAT, hist=0, fill=0, z=0, match_cnt=0.
  - Reset overrides every other input, including mid-stream; partial history is discarded.
- Priority at each edge: reset > pat_load > in_valid.
- pat_load=1:
  - pat_q<=pattern, hist<=0, fill<=0, z<=0.
  - A simultaneous in_valid bit is dropped.
  - match_cnt is kept.
- in_valid=1 (no load):
  - h_next = {hist[PAT_W-2:0], in}.
  - f_next = min(fill+1, PAT_W).
  - Match when f_next==PAT_W and h_next==pat_q.
- On a match:
  - z<=1.
  - overlap=1: hist<=h_next, fill<=PAT_W, so a later match may reuse bits.
  - overlap=0: hist<=h_next, fill<=0, so the next match needs PAT_W fresh bits.
- On no match: hist<=h_next, fill<=f_next, z<=0.
- in_valid=0: hist and fill hold; z<=0. Idle cycles do not break a sequence in progress.
- Effective state machine: fill levels 0..PAT_W-1 (collecting) plus PAT_W (primed). A match in non-overlap mode returns to level 0.
- Changing overlap affects only matches found at that same edge.

## Timing
- z rises on the edge that samples the completing bit. It is high for exactly one cycle and drops on the next edge, even if that edge has in_valid=0.
- Latency: completing bit at edge N gives z=1 during cycle N to N+1.
- Back-to-back matches in overlap mode (e.g. pattern of all ones) keep z high on consecutive cycles.
- match_cnt updates on the same edge as z.
  - Saturates at 2^CNT_W-1.
  - cnt_clr alone gives 0.
  - cnt_clr together with a match gives 1.
- Pattern change takes effect for bits sampled on edges after the load edge.

## Configuration
- SEQDET_CNT_EN
  - Defined: the match counter logic is present and behaves as described above.
  - Undefined: no counter flops; match_cnt is tied to 0 and cnt_clr is ignored. z behaviour is identical.

## Test plan
- Reset / default pattern:
  - Hold rst=0 for 2 edges with in_valid=1 and in=1. Then expect z=0, match_cnt=0, and pat_q=4'b1010.
  - Release reset and feed 1,0,1,0. Expect z=1 in exactly the cycle after the 4th bit.
- Overlap vs non-overlap, pattern 1010, stream 1,0,1,0,1,0,1,0:
  - overlap=1: z pulses after bits 4, 6 and 8; match_cnt=3.
  - overlap=0: z pulses after bits 4 and 8; match_cnt=2.
- Idle gaps: stream 1,0 then in_valid=0 for 3 cycles, then 1,0. Expect one z pulse after the last bit; z stays 0 during the gap.
- Load mid-stream:
  - Feed 1,0,1, then pat_load=1 with pattern=4'b0011 and in_valid=1 on the same edge.
  - Then feed 0,0,1,1. Expect z only after the 4th post-load bit; the dropped bit does not count.
- Counter (SEQDET_CNT_EN defined, CNT_W=2):
  - Produce 5 matches. Expect match_cnt to saturate at 3.
  - Assert cnt_clr on a match edge. Expect match_cnt=1.
  - Build without the macro: expect match_cnt=0 throughout.
- Legacy equivalence: PAT_W=2, pattern 2'b10, overlap=1, stream 1,1,0,1,0,0,1,0. Expect z after bits 3, 5 and 8.
